// File: rtl/parking_request_scheduler_if.sv
// Job interface between the parking request scheduler and the elevator FSM.
// master: scheduler drives todo_* and samples elev_done; slave: elevator side.
interface parking_request_scheduler_if;
    logic        todo_exists;
    logic        todo_in;
    logic        todo_out;
    logic        todo_leak_move;
    logic [15:0] todo_license_plate;
    logic [2:0]  todo_leak_floor;
    logic        elev_done;

    modport master (
        output todo_exists,
        output todo_in,
        output todo_out,
        output todo_leak_move,
        output todo_license_plate,
        output todo_leak_floor,
        input  elev_done
    );

    modport slave (
        input  todo_exists,
        input  todo_in,
        input  todo_out,
        input  todo_leak_move,
        input  todo_license_plate,
        input  todo_leak_floor,
        output elev_done
    );
endinterface

// File: rtl/parking_request_scheduler.sv
// Queues park/retrieve requests, arbitrates leakage evacuation, issues one job.
// Ports: clock/reset, panel inputs (plate, modes, leakage), job if (todo_*,
// elev_done), queue_count/queue_full status, drop_pulse and timeout_err pulses.
module parking_request_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [15:0]                  license_plate,
    input  logic                         in_mode,
    input  logic                         out_mode,
    input  logic                         leakage,
    input  logic [2:0]                   leakage_floor,
    parking_request_scheduler_if.master  job,
    output logic [3:0]                   queue_count,
    output logic                         queue_full,
    output logic                         drop_pulse,
    output logic                         timeout_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]    DEPTH_C = 4'(DEPTH);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        r_state, w_state_nxt;
    // Entry bit 16 set means retrieve, clear means park.
    logic [16:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [3:0]    r_count;
    logic          r_full;
    logic          r_leak_pend;
    logic [2:0]    r_leak_floor;
    logic [WW-1:0] r_wdog;
    logic          r_exists, r_in, r_out, r_leak;
    logic [15:0]   r_plate;
    logic [2:0]    r_floor;
    logic          r_drop, r_tmo;

    logic          w_avail, w_load, w_take_leak, w_pop;
    logic          w_clear, w_tmo, w_hold;
    logic          w_push, w_drop, w_leak_ok;
    logic [3:0]    w_count_nxt;
    logic [16:0]   w_head;

    assign w_avail   = r_leak_pend | (r_count != 4'd0);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_push    = (in_mode ^ out_mode) && (license_plate != 16'd0)
                       && (r_count != DEPTH_C);
    assign w_drop    = (in_mode | out_mode) && !w_push;
    assign w_leak_ok = leakage && (leakage_floor != 3'd0);
    assign w_count_nxt = r_count + 4'(w_push) - 4'(w_pop);

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_tmo       = 1'b0;
        w_hold      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_avail) begin
                    w_load      = 1'b1;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                // elev_done wins over a watchdog expiry on the same cycle.
                if (job.elev_done || r_wdog == WD_LAST) begin
                    w_tmo = !job.elev_done;
                    if (w_avail) begin
                        w_load = 1'b1;
                    end else begin
                        w_clear     = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_hold = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_take_leak = w_load && r_leak_pend;
        w_pop       = w_load && !r_leak_pend;
    end

    always_ff @(posedge clock) begin
        if (w_push && !reset) r_mem[r_wr_ptr] <= {out_mode, license_plate};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= 4'd0;
            r_full       <= 1'b0;
            r_leak_pend  <= 1'b0;
            r_leak_floor <= 3'd0;
            r_wdog       <= '0;
            r_exists     <= 1'b0;
            r_in         <= 1'b0;
            r_out        <= 1'b0;
            r_leak       <= 1'b0;
            r_plate      <= 16'd0;
            r_floor      <= 3'd0;
            r_drop       <= 1'b0;
            r_tmo        <= 1'b0;
        end else begin
            r_drop  <= w_drop;
            r_tmo   <= w_tmo;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_C);
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // A fresh leak event re-arms even while the old one is taken.
            if (w_leak_ok) begin
                r_leak_pend  <= 1'b1;
                r_leak_floor <= leakage_floor;
            end else if (w_take_leak) begin
                r_leak_pend  <= 1'b0;
            end
            if (w_hold) r_wdog <= r_wdog + 1'b1;
            else        r_wdog <= '0;
            if (w_take_leak) begin
                r_exists <= 1'b1;
                r_in     <= 1'b0;
                r_out    <= 1'b0;
                r_leak   <= 1'b1;
                r_plate  <= 16'd0;
                r_floor  <= r_leak_floor;
            end else if (w_pop) begin
                r_exists <= 1'b1;
                r_in     <= !w_head[16];
                r_out    <= w_head[16];
                r_leak   <= 1'b0;
                r_plate  <= w_head[15:0];
                r_floor  <= 3'd0;
            end else if (w_clear) begin
                r_exists <= 1'b0;
                r_in     <= 1'b0;
                r_out    <= 1'b0;
                r_leak   <= 1'b0;
                r_plate  <= 16'd0;
                r_floor  <= 3'd0;
            end
        end
    end

    assign job.todo_exists        = r_exists;
    assign job.todo_in            = r_in;
    assign job.todo_out           = r_out;
    assign job.todo_leak_move     = r_leak;
    assign job.todo_license_plate = r_plate;
    assign job.todo_leak_floor    = r_floor;
    assign queue_count            = r_count;
    assign queue_full             = r_full;
    assign drop_pulse             = r_drop;
    assign timeout_err            = r_tmo;
endmodule

// File: doc/parking_request_scheduler.md
Name: parking_request_scheduler

Overview:
- Buffers car-in, car-out and leakage-evacuation requests from the lot's front panel and issues them one at a time to the elevator/slot controller.
- Sits between the top-level inputs (license_plate, in_mode, out_mode, leakage, leakage_floor) and the elevator FSM.
- Drives the todo_* job interface and retires each job on the elevator's done pulse.
- Arbitrates leakage over queued in/out jobs and watchdogs stalled jobs.

Parameters:
- DEPTH, 4, in/out request FIFO entries (power of two, 2..8)
- TIMEOUT, 64, max cycles a job may stay active without elev_done before abort

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- license_plate  in  16  4-digit BCD plate, sampled with in_mode/out_mode
- in_mode  in  1  one-cycle request: park license_plate
- out_mode  in  1  one-cycle request: retrieve license_plate
- leakage  in  1  one-cycle leakage event
- leakage_floor  in  3  floor of leakage event (valid 1..7)
- elev_done  in  1  one-cycle pulse: elevator finished current job
- todo_exists  out  1  a job is active and held on todo_* outputs
- todo_in  out  1  active job is park
- todo_out  out  1  active job is retrieve
- todo_leak_move  out  1  active job is leakage evacuation
- todo_license_plate  out  16  plate of active job (0 for leak job)
- todo_leak_floor  out  3  floor to evacuate (0 unless leak job)
- queue_count  out  4  FIFO occupancy 0..DEPTH
- queue_full  out  1  queue_count == DEPTH
- drop_pulse  out  1  one-cycle pulse: a request was discarded
- timeout_err  out  1  one-cycle pulse: active job aborted by watchdog

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FIFO empty, leak_pending cleared, FSM to IDLE, watchdog 0. Reset asserted mid-job abandons the job silently; no drop_pulse or timeout_err is raised.
- Request acceptance, evaluated every edge:
  - in_mode XOR out_mode with license_plate != 0 pushes {type, plate}.
  - in_mode & out_mode both 1, or plate == 0 with either mode set, is discarded with drop_pulse.
  - A push while queue_count == DEPTH (count before the edge) is discarded with drop_pulse, even if a pop occurs on the same edge.
- Leakage acceptance:
  - leakage=1 with leakage_floor in 1..7 sets leak_pending and stores the floor.
  - A second event while pending overwrites the stored floor.
  - leakage_floor 0 is ignored with no drop_pulse.
  - Leakage is independent of FIFO full state.
- FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE when leak_pending or FIFO non-empty. Leak has priority: load leak job (todo_leak_move=1, plate 0, floor) and clear leak_pending. Otherwise pop the FIFO head.
  - ACTIVE: todo_* held stable, todo_exists=1, watchdog increments each cycle.
  - ACTIVE, on elev_done: if another job is available, load it on that same edge (zero-bubble), watchdog to 0. If none, go to IDLE and clear todo_* to 0.
  - ACTIVE, watchdog reaches TIMEOUT-1 without elev_done: pulse timeout_err, retire the job, and continue exactly as for elev_done.
  - elev_done in IDLE is ignored.
- Leak never preempts an active job; it waits for retirement.
- Latency: a request sampled at edge T into an empty FIFO with FSM IDLE is pushed at T and visible on todo_* after edge T+1 (2 cycles from input to todo_exists).
- The leak path uses the same timing: leak sampled at T, leak job visible after T+1.
- A simultaneous push and pop on one edge leaves queue_count unchanged.
- FIFO order is strict FIFO. Pointers wrap modulo DEPTH.
- Exactly one of todo_in/todo_out/todo_leak_move is 1 when todo_exists=1; all are 0 otherwise.
- queue_count and queue_full are registered and reflect state after each edge.

Test Plan:
1. Reset, in_mode with 9423 at T -> todo_exists=1, todo_in=1, plate 9423 after T+1. elev_done pulse -> all todo_* 0 next cycle, queue_count 0.
2. While job 9423 is active, push 8754 in, 5755 in, 6755 in, 3851 in (DEPTH=4), then 9522 in. -> queue_full=1 and 9522 dropped with drop_pulse. Four elev_done pulses retire jobs in order 8754, 5755, 6755, 3851 with zero bubble.
3. Two jobs queued, job active, leakage floor 3 then floor 5 on the next cycle. -> after elev_done, next job is todo_leak_move=1, todo_leak_floor=5, plate 0. Queued jobs follow in order.
4. in_mode=out_mode=1 with plate 1234; in_mode with plate 0; leakage with floor 0. -> two drop_pulses, no push, leak_pending stays 0.
5. Active job, no elev_done for TIMEOUT cycles -> timeout_err pulses exactly once, next queued job loads on the same edge, or FSM goes IDLE if none.
6. Reset asserted while a job is active and the FIFO holds 3 entries. -> next cycle all outputs 0, queue_count 0, no stale jobs issued after reset deasserts.
